video_stream_source: RTL and testbench



---
 rtl/video_stream_source.sv | 159 +++++++++++++++
 tb/tb_video_stream_source.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_stream_source.sv
// rtl/video_stream_source.sv - framebuffer scanout master producing an AXI4-Stream video feed
//
// Reads width x height 32-bit words line by line from a synchronous memory
// read port and streams them out with tuser on the first beat of each frame
// and tlast on the last beat of each line.
//
// Ports:
//   m_axis_vid_aclk   clock
//   areset            asynchronous active-high reset
//   enable            level; frames repeat back to back while high
//   cfg_base/pitch/width/height  frame geometry, sampled at frame start
//   mem_rd_en/addr    read strobe and word-aligned byte address
//   mem_rd_data       data for the read issued one cycle earlier
//   m_axis_vid_*      output video stream
//   frame_done        one-cycle pulse when the last beat of a frame is accepted
//   busy              high from frame start until frame_done

module video_stream_source #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              m_axis_vid_aclk,
  input  logic              areset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [15:0]       cfg_pitch,
  input  logic [11:0]       cfg_width,
  input  logic [11:0]       cfg_height,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [31:0]       mem_rd_data,
  output logic [31:0]       m_axis_vid_tdata,
  output logic              m_axis_vid_tvalid,
  input  logic              m_axis_vid_tready,
  output logic              m_axis_vid_tlast,
  output logic              m_axis_vid_tuser,
  output logic              frame_done,
  output logic              busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 2;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [15:0]       pitch_r;
  logic [11:0]       width_r, height_r;
  logic [ADDR_W-1:0] line_addr;
  logic [11:0]       x, y;

  // Tags travel with the read for one cycle: {eof, sof, eol}.
  logic              rd_pending;
  logic [2:0]        rd_tag;

  // FIFO entry: {eof, sof, eol, data}. eof marks the final beat of the frame.
  logic [34:0]       fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [34:0]       head;

  logic start, issue, last_x, last_y, push, pop;

  assign start  = (state == IDLE) && enable && (cfg_width != 12'd0) && (cfg_height != 12'd0);
  assign last_x = (x == width_r - 12'd1);
  assign last_y = (y == height_r - 12'd1);
  // Credit check: reads in flight reserve a FIFO slot, so a push never finds it full.
  assign issue  = (state == FETCH) && ((count + CW'(rd_pending)) < CW'(FIFO_DEPTH));

  assign push = rd_pending;
  assign pop  = m_axis_vid_tvalid && m_axis_vid_tready;
  assign head = fifo_mem[rd_ptr];

  assign mem_rd_en         = issue;
  assign mem_rd_addr       = line_addr + ADDR_W'({x, 2'b00});
  assign m_axis_vid_tvalid = (count != '0);
  assign m_axis_vid_tdata  = head[31:0];
  assign m_axis_vid_tlast  = head[32];
  assign m_axis_vid_tuser  = head[33];
  assign frame_done        = pop && head[34];
  assign busy              = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   if (issue && last_x && last_y) state_nxt = DRAIN;
      DRAIN:   if (frame_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge m_axis_vid_aclk or posedge areset) begin
    if (areset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge m_axis_vid_aclk or posedge areset) begin
    if (areset) begin
      pitch_r   <= 16'd0;
      width_r   <= 12'd0;
      height_r  <= 12'd0;
      line_addr <= '0;
      x         <= 12'd0;
      y         <= 12'd0;
    end else if (start) begin
      pitch_r   <= cfg_pitch;
      width_r   <= cfg_width;
      height_r  <= cfg_height;
      line_addr <= cfg_base;
      x         <= 12'd0;
      y         <= 12'd0;
    end else if (issue) begin
      if (last_x) begin
        x         <= 12'd0;
        y         <= y + 12'd1;
        line_addr <= line_addr + ADDR_W'(pitch_r);
      end else begin
        x <= x + 12'd1;
      end
    end
  end

  always_ff @(posedge m_axis_vid_aclk or posedge areset) begin
    if (areset) begin
      rd_pending <= 1'b0;
      rd_tag     <= 3'b000;
    end else begin
      rd_pending <= issue;
      rd_tag     <= {last_x && last_y, (x == 12'd0) && (y == 12'd0), last_x};
    end
  end

  always_ff @(posedge m_axis_vid_aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {rd_tag, mem_rd_data};
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_video_stream_source.sv
// tb/tb_video_stream_source.sv - self-checking bench for video_stream_source

module tb_video_stream_source;

  logic        clk = 1'b0;
  logic        areset;
  logic        enable;
  logic [31:0] cfg_base;
  logic [15:0] cfg_pitch;
  logic [11:0] cfg_width;
  logic [11:0] cfg_height;
  logic        mem_rd_en;
  logic [31:0] mem_rd_addr;
  logic [31:0] mem_rd_data = 32'd0;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic        tuser;
  logic        frame_done;
  logic        busy;

  always #5 clk = ~clk;

  video_stream_source #(.FIFO_DEPTH(4), .ADDR_W(32)) dut (
    .m_axis_vid_aclk   (clk),
    .areset            (areset),
    .enable            (enable),
    .cfg_base          (cfg_base),
    .cfg_pitch         (cfg_pitch),
    .cfg_width         (cfg_width),
    .cfg_height        (cfg_height),
    .mem_rd_en         (mem_rd_en),
    .mem_rd_addr       (mem_rd_addr),
    .mem_rd_data       (mem_rd_data),
    .m_axis_vid_tdata  (tdata),
    .m_axis_vid_tvalid (tvalid),
    .m_axis_vid_tready (tready),
    .m_axis_vid_tlast  (tlast),
    .m_axis_vid_tuser  (tuser),
    .frame_done        (frame_done),
    .busy              (busy)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Synchronous memory: data appears the cycle after the read strobe.
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= word_at(mem_rd_addr);

  typedef struct packed {
    logic [31:0] d;
    logic        u;
    logic        l;
    logic        e;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] addr_q[$];

  int   n_checks = 0, n_errors = 0;
  int   cyc = 0, rd_cnt = 0, beat_cnt = 0, fd_cnt = 0, fd_cyc = 0, rd_gap = 0;
  int   idle_run = 0, last_idle_run = 0, rd0_cyc = 0, v0_cyc = 0, acc_cyc = 0, rd_resume_cyc = 0;
  bit   await_rd = 0, f_rd = 0, f_v = 0, acc_wait = 0, rd_wait = 0;
  bit   prev_stall = 0, prev_busy = 0, rnd_rdy = 0;
  logic [33:0] prev_word = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: every beat of a frame from plain 2-D arithmetic.
  task automatic load_frame(input logic [31:0] base, input logic [15:0] pitch, input int w, input int h);
    beat_t       b;
    logic [31:0] a;
    for (int yy = 0; yy < h; yy++) begin
      for (int xx = 0; xx < w; xx++) begin
        a   = base + 32'(yy) * 32'(pitch) + 32'(4 * xx);
        b.d = word_at(a);
        b.u = (xx == 0 && yy == 0);
        b.l = (xx == w - 1);
        b.e = (xx == w - 1 && yy == h - 1);
        addr_q.push_back(a);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic set_cfg(input logic [31:0] base, input logic [15:0] pitch, input int w, input int h);
    cfg_base   = base;
    cfg_pitch  = pitch;
    cfg_width  = 12'(w);
    cfg_height = 12'(h);
  endtask

  task automatic monitor();
    beat_t e;
    if (areset) begin
      prev_stall = 0;
      prev_busy  = 0;
      return;
    end
    if (busy && !prev_busy) begin
      f_rd = 1; f_v = 1; acc_wait = 1; rd_wait = 0;
    end
    if (busy) begin
      if (idle_run > 0) last_idle_run = idle_run;
      idle_run = 0;
    end else begin
      idle_run++;
    end
    prev_busy = busy;

    if (prev_stall) begin
      check("hold_valid", 64'(tvalid), 64'(1));
      check("hold_beat", 64'({tuser, tlast, tdata}), 64'(prev_word));
    end
    prev_stall = tvalid && !tready;
    prev_word  = {tuser, tlast, tdata};

    if (tvalid && f_v) begin
      v0_cyc = cyc; f_v = 0;
    end
    if (tvalid && tready) begin
      beat_cnt++;
      if (acc_wait) begin
        acc_cyc = cyc; acc_wait = 0; rd_wait = 1;
      end
      check("beat_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("tdata", 64'(tdata), 64'(e.d));
        check("tuser", 64'(tuser), 64'(e.u));
        check("tlast", 64'(tlast), 64'(e.l));
        check("frame_done", 64'(frame_done), 64'(e.e));
      end
      if (frame_done) begin
        fd_cnt++; fd_cyc = cyc; await_rd = 1;
      end
    end else begin
      check("frame_done_idle", 64'(frame_done), 64'(0));
    end

    if (mem_rd_en) begin
      rd_cnt++;
      if (f_rd) begin
        rd0_cyc = cyc; f_rd = 0;
      end
      if (rd_wait) begin
        rd_resume_cyc = cyc; rd_wait = 0;
      end
      if (await_rd) begin
        rd_gap = cyc - fd_cyc; await_rd = 0;
      end
      check("rd_expected", 64'(addr_q.size() != 0), 64'(1));
      if (addr_q.size() != 0) check("rd_addr", 64'(mem_rd_addr), 64'(addr_q.pop_front()));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
    if (rnd_rdy) tready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_frames(input int target, input int budget, input string tag);
    int n = 0;
    while (fd_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, 64'(fd_cnt >= target), 64'(1));
  endtask

  task automatic pulse_enable();
    enable = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  initial begin
    int r0, n, w, h;
    logic [31:0] base;
    logic [15:0] pitch;

    areset = 1'b1;
    enable = 1'b0;
    tready = 1'b0;
    set_cfg(32'h0, 16'h0, 0, 0);
    repeat (3) tick();
    check("rst_tvalid", 64'(tvalid), 64'(0));
    check("rst_tlast", 64'(tlast), 64'(0));
    check("rst_tuser", 64'(tuser), 64'(0));
    check("rst_tdata", 64'(tdata), 64'(0));
    check("rst_rd_en", 64'(mem_rd_en), 64'(0));
    check("rst_frame_done", 64'(frame_done), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    areset = 1'b0;
    tick();

    // Basic 4x2 frame, sink always ready.
    tready = 1'b1;
    set_cfg(32'h1000, 16'h40, 4, 2);
    load_frame(32'h1000, 16'h40, 4, 2);
    pulse_enable();
    wait_frames(1, 200, "t1");
    check("t1_busy_after", 64'(busy), 64'(0));
    check("t1_latency", 64'(v0_cyc - rd0_cyc), 64'(2));
    check("t1_throughput", 64'(fd_cyc - v0_cyc), 64'(7));
    check("t1_q_empty", 64'(exp_q.size() + addr_q.size()), 64'(0));

    // Same frame with random back-pressure.
    rnd_rdy = 1;
    load_frame(32'h1000, 16'h40, 4, 2);
    pulse_enable();
    wait_frames(2, 400, "t2");
    rnd_rdy = 0;

    // Sink stalled from frame start: credit limits reads to the FIFO depth.
    tready = 1'b0;
    r0 = rd_cnt;
    load_frame(32'h1000, 16'h40, 4, 2);
    pulse_enable();
    repeat (19) tick();
    check("t3_stalled_reads", 64'(rd_cnt - r0), 64'(4));
    tready = 1'b1;
    wait_frames(3, 200, "t3");
    check("t3_resume", 64'((rd_resume_cyc - acc_cyc) <= 1), 64'(1));

    // Single-beat frame, one-cycle enable.
    set_cfg(32'h2000, 16'h4, 1, 1);
    load_frame(32'h2000, 16'h4, 1, 1);
    pulse_enable();
    wait_frames(4, 100, "t4");
    r0 = rd_cnt;
    repeat (10) tick();
    check("t4_no_second_rd", 64'(rd_cnt - r0), 64'(0));
    check("t4_busy", 64'(busy), 64'(0));
    check("t4_frames", 64'(fd_cnt), 64'(4));

    // Enable dropped after beat 2: frame still completes, then idle.
    set_cfg(32'h1000, 16'h40, 4, 2);
    load_frame(32'h1000, 16'h40, 4, 2);
    enable = 1'b1;
    r0 = beat_cnt;
    n = 0;
    while (beat_cnt < r0 + 3 && n < 100) begin
      tick();
      n++;
    end
    check("t5_beats_timeout", 64'(beat_cnt >= r0 + 3), 64'(1));
    enable = 1'b0;
    wait_frames(5, 200, "t5");
    r0 = rd_cnt;
    repeat (10) tick();
    check("t5_no_more_rd", 64'(rd_cnt - r0), 64'(0));
    check("t5_frames", 64'(fd_cnt), 64'(5));
    check("t5_q_empty", 64'(exp_q.size() + addr_q.size()), 64'(0));

    // Enable held: back-to-back frames with one idle cycle between them.
    load_frame(32'h1000, 16'h40, 4, 2);
    load_frame(32'h1000, 16'h40, 4, 2);
    enable = 1'b1;
    wait_frames(6, 200, "t5b");
    n = 0;
    while (!busy && n < 20) begin
      tick();
      n++;
    end
    check("t5b_restart", 64'(busy), 64'(1));
    tick();
    enable = 1'b0;
    wait_frames(7, 200, "t5c");
    check("t5_idle_cycles", 64'(last_idle_run), 64'(1));
    check("t5_rd_gap", 64'(rd_gap), 64'(2));

    // Reset mid-frame.
    set_cfg(32'h3000, 16'h100, 4, 2);
    load_frame(32'h3000, 16'h100, 4, 2);
    tready = 1'b0;
    enable = 1'b1;
    repeat (4) tick();
    check("t6_pre_rst_valid", 64'(tvalid), 64'(1));
    areset = 1'b1;
    #1;
    check("t6_rst_tvalid", 64'(tvalid), 64'(0));
    check("t6_rst_rd_en", 64'(mem_rd_en), 64'(0));
    check("t6_rst_busy", 64'(busy), 64'(0));
    exp_q.delete();
    addr_q.delete();
    load_frame(32'h3000, 16'h100, 4, 2);
    tready = 1'b1;
    tick();
    areset = 1'b0;
    tick();
    enable = 1'b0;
    wait_frames(8, 200, "t6");

    // Random geometry, random back-pressure, cfg scrambled mid-frame.
    rnd_rdy = 1;
    for (int i = 0; i < 8; i++) begin
      w     = $urandom_range(1, 6);
      h     = $urandom_range(1, 4);
      base  = $urandom & 32'hFFFF_FFFC;
      if (i % 2 == 1) base = base | 32'hFFFF_FF00;
      pitch = 16'($urandom) & 16'hFFFC;
      set_cfg(base, pitch, w, h);
      load_frame(base, pitch, w, h);
      pulse_enable();
      set_cfg($urandom, 16'($urandom), $urandom_range(0, 7), $urandom_range(0, 7));
      wait_frames(9 + i, 1000, "t7");
    end
    rnd_rdy = 0;
    check("t7_q_empty", 64'(exp_q.size() + addr_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
